// File: rtl/mmio_seq_multiplier_pkg.sv
// Shared definitions for the memory-mapped sequential multiplier:
// register word indices, CTRL/STATUS bit positions, FSM states and
// a byte-lane merge helper used by the register file.
package mmio_seq_multiplier_pkg;

  // Register word indices (byte offset >> 2) inside the 32-byte window
  localparam logic [2:0] IDX_A      = 3'd0;
  localparam logic [2:0] IDX_B      = 3'd1;
  localparam logic [2:0] IDX_CTRL   = 3'd2;
  localparam logic [2:0] IDX_STATUS = 3'd3;
  localparam logic [2:0] IDX_RES_LO = 3'd4;
  localparam logic [2:0] IDX_RES_HI = 3'd5;

  // CTRL bit positions
  localparam int CTRL_START  = 0;
  localparam int CTRL_SIGNED = 1;
  localparam int CTRL_ACC    = 2;
  localparam int CTRL_CLR    = 3;

  // STATUS bit positions
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_OVF  = 2;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } mulState_e;

  // Replace the byte lanes of oldWord selected by strb with those of newWord
  function automatic logic [31:0] mergeBytes(input logic [31:0] oldWord,
                                             input logic [31:0] newWord,
                                             input logic [3:0]  strb);
    logic [31:0] merged;
    merged = oldWord;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) merged[i*8 +: 8] = newWord[i*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/mmio_seq_multiplier_if.sv
// picorv32 look-ahead memory bus as seen by the multiplier peripheral.
// The CPU/system side uses the master view, the peripheral the slave view.
interface mmio_seq_multiplier_if;
  logic        mem_la_read;
  logic        mem_la_write;
  logic [31:0] mem_la_addr;
  logic [31:0] mem_la_wdata;
  logic [3:0]  mem_la_wstrb;
  logic [31:0] rdata;
  logic        hit;

  modport master (
    output mem_la_read, mem_la_write, mem_la_addr, mem_la_wdata, mem_la_wstrb,
    input  rdata, hit
  );

  modport slave (
    input  mem_la_read, mem_la_write, mem_la_addr, mem_la_wdata, mem_la_wstrb,
    output rdata, hit
  );
endinterface

// File: rtl/mmio_seq_multiplier_mul_radix_step.sv
// One radix step of the shift-add multiplier: adds the pre-shifted
// multiplicand times a BPC-bit multiplier slice into the partial sum.
module mul_radix_step
  import mmio_seq_multiplier_pkg::*;
#(
  parameter int W   = 64,
  parameter int BPC = 1
) (
  input  logic [W-1:0]   i_mcand,
  input  logic [BPC-1:0] i_slice,
  input  logic [W-1:0]   i_psum,
  output logic [W-1:0]   o_psum
);

  logic [W-1:0] w_sum;

  // Sum of the partial sum and each multiplicand copy selected by a slice bit
  always_comb begin
    w_sum = i_psum;
    for (int j = 0; j < BPC; j++) begin
      if (i_slice[j]) w_sum = w_sum + (i_mcand << j);
    end
  end

  assign o_psum = w_sum;

endmodule

// File: rtl/mmio_seq_multiplier.sv
// Memory-mapped sequential multiply / multiply-accumulate peripheral.
// Retires BPC multiplier bits per cycle, so an operation takes N/BPC
// RUN cycles plus one FIN cycle that signs, accumulates and reports.
module mmio_seq_multiplier
  import mmio_seq_multiplier_pkg::*;
#(
  parameter int          N         = 32,
  parameter int          BPC       = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0FFF_FFE0
) (
  input  logic                  clk,
  input  logic                  resetn,
  mmio_seq_multiplier_if.slave  bus,
  output logic                  busy,
  output logic                  irq
);

  localparam int W2    = 2 * N;
  localparam int STEPS = N / BPC;
  localparam int CW    = $clog2(STEPS + 1);

  // Bus decode
  logic        w_inWindow;
  logic [2:0]  w_index;
  logic        w_wr;
  logic        w_rd;
  logic        w_ctrlWr;
  logic        w_start;
  logic        w_clr;
  logic        w_statusRd;
  logic [31:0] w_mergedA;
  logic [31:0] w_mergedB;
  logic [31:0] w_readVal;

  // Programmer-visible registers
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic          r_ctrlSigned;
  logic          r_ctrlAcc;
  logic          r_busy;
  logic          r_done;
  logic          r_ovf;
  logic          r_irq;
  logic [W2-1:0] r_res;
  logic          r_resSigned;
  logic [31:0]   r_rdata;
  logic          r_hit;

  // Working copies of the running operation
  mulState_e     r_state;
  mulState_e     w_stateNext;
  logic          w_launch;
  logic          w_finish;
  logic [W2-1:0] r_mcand;
  logic [N-1:0]  r_mplier;
  logic [W2-1:0] r_psum;
  logic [CW-1:0] r_count;
  logic          r_neg;
  logic          r_opSigned;
  logic          r_opAcc;

  // Datapath
  logic          w_wSigned;
  logic [N-1:0]  w_absA;
  logic [N-1:0]  w_absB;
  logic [W2-1:0] w_psumNext;
  logic [W2-1:0] w_product;
  logic [W2:0]   w_accSum;
  logic          w_signedOvf;
  logic          w_ovfSet;
  logic [W2-1:0] w_resNext;
  logic [63:0]   w_res64;

  // The CPU only issues word-aligned look-ahead addresses
  assign w_inWindow = (bus.mem_la_addr[31:5] == BASE_ADDR[31:5]) &&
                      (bus.mem_la_addr[1:0] == 2'b00);
  assign w_index    = bus.mem_la_addr[4:2];
  assign w_wr       = bus.mem_la_write && w_inWindow;
  assign w_rd       = bus.mem_la_read && w_inWindow;
  assign w_ctrlWr   = w_wr && (w_index == IDX_CTRL) && bus.mem_la_wstrb[0];
  assign w_start    = w_ctrlWr && bus.mem_la_wdata[CTRL_START];
  assign w_clr      = w_ctrlWr && bus.mem_la_wdata[CTRL_CLR];
  assign w_statusRd = w_rd && (w_index == IDX_STATUS);

  assign w_mergedA = mergeBytes(32'(r_a), bus.mem_la_wdata, bus.mem_la_wstrb);
  assign w_mergedB = mergeBytes(32'(r_b), bus.mem_la_wdata, bus.mem_la_wstrb);

  // SIGNED comes from the same write that carries START
  assign w_wSigned = bus.mem_la_wdata[CTRL_SIGNED];
  assign w_absA    = (w_wSigned && r_a[N-1]) ? (-r_a) : r_a;
  assign w_absB    = (w_wSigned && r_b[N-1]) ? (-r_b) : r_b;

  mul_radix_step #(
    .W   (W2),
    .BPC (BPC)
  ) u_step (
    .i_mcand (r_mcand),
    .i_slice (r_mplier[BPC-1:0]),
    .i_psum  (r_psum),
    .o_psum  (w_psumNext)
  );

  assign w_product   = r_neg ? (-r_psum) : r_psum;
  assign w_accSum    = {1'b0, r_res} + {1'b0, w_product};
  assign w_signedOvf = (r_res[W2-1] == w_product[W2-1]) &&
                       (w_accSum[W2-1] != r_res[W2-1]);
  assign w_ovfSet    = r_opAcc && (r_opSigned ? w_signedOvf : w_accSum[W2]);
  assign w_resNext   = r_opAcc ? w_accSum[W2-1:0] : w_product;

  // Present the 2N-bit result as 64 bits, extended per the last op's mode
  always_comb begin
    w_res64 = r_resSigned ? 64'($signed(r_res)) : 64'(r_res);
  end

  // Read data mux for the addressed register
  always_comb begin
    w_readVal = '0;
    case (w_index)
      IDX_A:      w_readVal = 32'(r_a);
      IDX_B:      w_readVal = 32'(r_b);
      IDX_CTRL:   w_readVal = {28'd0, 1'b0, r_ctrlAcc, r_ctrlSigned, 1'b0};
      IDX_STATUS: w_readVal = {29'd0, r_ovf, r_done, r_busy};
      IDX_RES_LO: w_readVal = w_res64[31:0];
      IDX_RES_HI: w_readVal = w_res64[63:32];
      default:    w_readVal = '0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_stateNext;
  end

  // FSM next state: START is only honoured from IDLE
  always_comb begin
    w_stateNext = r_state;
    w_launch    = 1'b0;
    w_finish    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_start) begin
          w_stateNext = RUN;
          w_launch    = 1'b1;
        end
      end
      RUN: begin
        if (r_count == CW'(1)) w_stateNext = FIN;
      end
      FIN: begin
        w_stateNext = IDLE;
        w_finish    = 1'b1;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // Register file: A/B byte-lane writes and the persistent CTRL mode bits
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_a          <= '0;
      r_b          <= '0;
      r_ctrlSigned <= 1'b0;
      r_ctrlAcc    <= 1'b0;
    end else begin
      if (w_wr && (w_index == IDX_A)) r_a <= w_mergedA[N-1:0];
      if (w_wr && (w_index == IDX_B)) r_b <= w_mergedB[N-1:0];
      if (w_ctrlWr) begin
        r_ctrlSigned <= bus.mem_la_wdata[CTRL_SIGNED];
        r_ctrlAcc    <= bus.mem_la_wdata[CTRL_ACC];
      end
    end
  end

  // Multiply engine and status: DONE set in FIN overrides a STATUS-read clear
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_psum      <= '0;
      r_count     <= '0;
      r_neg       <= 1'b0;
      r_opSigned  <= 1'b0;
      r_opAcc     <= 1'b0;
      r_res       <= '0;
      r_resSigned <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ovf       <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      r_irq <= w_finish;
      if (w_statusRd) r_done <= 1'b0;
      if (w_clr && (r_state == IDLE)) begin
        r_res <= '0;
        r_ovf <= 1'b0;
      end
      if (w_launch) begin
        r_mcand    <= W2'(w_absA);
        r_mplier   <= w_absB;
        r_psum     <= '0;
        r_count    <= CW'(STEPS);
        r_neg      <= w_wSigned && (r_a[N-1] ^ r_b[N-1]);
        r_opSigned <= w_wSigned;
        r_opAcc    <= bus.mem_la_wdata[CTRL_ACC];
        r_busy     <= 1'b1;
        r_done     <= 1'b0;
      end
      if (r_state == RUN) begin
        r_psum   <= w_psumNext;
        r_mcand  <= r_mcand << BPC;
        r_mplier <= r_mplier >> BPC;
        r_count  <= r_count - CW'(1);
      end
      if (w_finish) begin
        r_res       <= w_resNext;
        r_resSigned <= r_opSigned;
        if (w_ovfSet) r_ovf <= 1'b1;
        r_busy      <= 1'b0;
        r_done      <= 1'b1;
      end
    end
  end

  // Registered read return, one cycle after the look-ahead read strobe
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rdata <= '0;
      r_hit   <= 1'b0;
    end else begin
      r_hit   <= w_rd;
      r_rdata <= w_rd ? w_readVal : '0;
    end
  end

  assign bus.rdata = r_rdata;
  assign bus.hit   = r_hit;
  assign busy      = r_busy;
  assign irq       = r_irq;

endmodule

// File: tb/tb_mmio_seq_multiplier.sv
// Directed bench for mmio_seq_multiplier: a default 32x32 radix-2 instance
// and a 16-bit, 4-bits-per-cycle instance share clock and reset.
module tb_mmio_seq_multiplier;

  localparam logic [31:0] BASE       = 32'h0FFF_FFE0;
  localparam logic [4:0]  OFF_A      = 5'h00;
  localparam logic [4:0]  OFF_B      = 5'h04;
  localparam logic [4:0]  OFF_CTRL   = 5'h08;
  localparam logic [4:0]  OFF_STATUS = 5'h0C;
  localparam logic [4:0]  OFF_RES_LO = 5'h10;
  localparam logic [4:0]  OFF_RES_HI = 5'h14;
  localparam logic [4:0]  OFF_SPARE  = 5'h18;

  logic clk;
  logic resetn;
  logic busyA, irqA, busyB, irqB;

  int vectorCount = 0;
  int missCount   = 0;

  mmio_seq_multiplier_if busA();
  mmio_seq_multiplier_if busB();

  mmio_seq_multiplier #(.N(32), .BPC(1), .BASE_ADDR(BASE)) dutA (
    .clk    (clk),
    .resetn (resetn),
    .bus    (busA),
    .busy   (busyA),
    .irq    (irqA)
  );

  mmio_seq_multiplier #(.N(16), .BPC(4), .BASE_ADDR(BASE)) dutB (
    .clk    (clk),
    .resetn (resetn),
    .bus    (busB),
    .busy   (busyB),
    .irq    (irqB)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic driveBus(input bit sel, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb);
    if (sel) begin
      busB.mem_la_read  = rd;
      busB.mem_la_write = wr;
      busB.mem_la_addr  = addr;
      busB.mem_la_wdata = data;
      busB.mem_la_wstrb = strb;
    end else begin
      busA.mem_la_read  = rd;
      busA.mem_la_write = wr;
      busA.mem_la_addr  = addr;
      busA.mem_la_wdata = data;
      busA.mem_la_wstrb = strb;
    end
  endtask

  // One-cycle register write; returns just after the sampling edge
  task automatic applyStimulus(input bit sel, input logic [4:0] off,
                               input logic [31:0] data, input logic [3:0] strb);
    @(negedge clk);
    driveBus(sel, 1'b0, 1'b1, BASE + 32'(off), data, strb);
    @(posedge clk);
    #1;
    driveBus(sel, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic busRead(input bit sel, input logic [31:0] addr,
                         output logic [31:0] data, output logic hitSeen);
    @(negedge clk);
    driveBus(sel, 1'b1, 1'b0, addr, '0, '0);
    @(posedge clk);
    #1;
    driveBus(sel, 1'b0, 1'b0, '0, '0, '0);
    data    = sel ? busB.rdata : busA.rdata;
    hitSeen = sel ? busB.hit : busA.hit;
  endtask

  task automatic readReg(input bit sel, input logic [4:0] off, output logic [31:0] data);
    logic hitSeen;
    busRead(sel, BASE + 32'(off), data, hitSeen);
  endtask

  // Cycle 0 is the state right after the START edge; bounded wait for irq
  task automatic waitDone(input bit sel, output int cycles, output bit timedOut);
    cycles = 0;
    @(negedge clk);
    while (!(sel ? irqB : irqA) && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
    timedOut = !(sel ? irqB : irqA);
  endtask

  initial begin
    logic [31:0] rd;
    logic        hitSeen;
    int          cycles;
    bit          timedOut;
    int          irqSeen;

    driveBus(1'b0, 1'b0, 1'b0, '0, '0, '0);
    driveBus(1'b1, 1'b0, 1'b0, '0, '0, '0);
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", 32'(busyA), 32'h0);
    checkOutput("reset irq", 32'(irqA), 32'h0);
    checkOutput("reset hit", 32'(busA.hit), 32'h0);
    checkOutput("reset rdata", busA.rdata, 32'h0);
    resetn = 1'b1;

    readReg(1'b0, OFF_STATUS, rd);
    checkOutput("reset status", rd, 32'h0);
    readReg(1'b0, OFF_RES_HI, rd);
    checkOutput("reset res_hi", rd, 32'h0);

    // Byte-lane writes, spare offset and out-of-window decode
    applyStimulus(1'b0, OFF_A, 32'h1122_3344, 4'hF);
    applyStimulus(1'b0, OFF_A, 32'hAABB_CCDD, 4'b0101);
    readReg(1'b0, OFF_A, rd);
    checkOutput("A byte strobes", rd, 32'h11BB_33DD);
    busRead(1'b0, BASE + 32'(OFF_SPARE), rd, hitSeen);
    checkOutput("spare data", rd, 32'h0);
    checkOutput("spare hit", 32'(hitSeen), 32'h1);
    busRead(1'b0, BASE + 32'h20, rd, hitSeen);
    checkOutput("outside hit", 32'(hitSeen), 32'h0);

    // Unsigned full-scale product and latency
    applyStimulus(1'b0, OFF_A, 32'hFFFF_FFFF, 4'hF);
    applyStimulus(1'b0, OFF_B, 32'hFFFF_FFFF, 4'hF);
    applyStimulus(1'b0, OFF_CTRL, 32'h1, 4'hF);
    checkOutput("busy after start", 32'(busyA), 32'h1);
    waitDone(1'b0, cycles, timedOut);
    checkOutput("unsigned latency", 32'(cycles), 32'd33);
    checkOutput("busy at done", 32'(busyA), 32'h0);
    @(negedge clk);
    checkOutput("irq single pulse", 32'(irqA), 32'h0);
    readReg(1'b0, OFF_RES_LO, rd);
    checkOutput("unsigned res_lo", rd, 32'h0000_0001);
    readReg(1'b0, OFF_RES_HI, rd);
    checkOutput("unsigned res_hi", rd, 32'hFFFF_FFFE);
    readReg(1'b0, OFF_STATUS, rd);
    checkOutput("status done", rd, 32'h2);
    readReg(1'b0, OFF_STATUS, rd);
    checkOutput("status cleared", rd, 32'h0);

    // Signed: -3 * 7
    applyStimulus(1'b0, OFF_A, 32'hFFFF_FFFD, 4'hF);
    applyStimulus(1'b0, OFF_B, 32'h0000_0007, 4'hF);
    applyStimulus(1'b0, OFF_CTRL, 32'h3, 4'hF);
    waitDone(1'b0, cycles, timedOut);
    checkOutput("signed timeout", 32'(timedOut), 32'h0);
    readReg(1'b0, OFF_RES_LO, rd);
    checkOutput("signed res_lo", rd, 32'hFFFF_FFEB);
    readReg(1'b0, OFF_RES_HI, rd);
    checkOutput("signed res_hi", rd, 32'hFFFF_FFFF);
    readReg(1'b0, OFF_CTRL, rd);
    checkOutput("ctrl readback", rd, 32'h2);

    // Hazards: RES read, A write and second START while busy
    applyStimulus(1'b0, OFF_A, 32'd6, 4'hF);
    applyStimulus(1'b0, OFF_B, 32'd7, 4'hF);
    applyStimulus(1'b0, OFF_CTRL, 32'h1, 4'hF);
    readReg(1'b0, OFF_RES_LO, rd);
    checkOutput("res while busy", rd, 32'hFFFF_FFEB);
    readReg(1'b0, OFF_STATUS, rd);
    checkOutput("status while busy", rd, 32'h1);
    applyStimulus(1'b0, OFF_A, 32'd0, 4'hF);
    applyStimulus(1'b0, OFF_CTRL, 32'h1, 4'hF);
    waitDone(1'b0, cycles, timedOut);
    checkOutput("hazard timeout", 32'(timedOut), 32'h0);
    readReg(1'b0, OFF_RES_LO, rd);
    checkOutput("hazard res_lo", rd, 32'd42);
    readReg(1'b0, OFF_RES_HI, rd);
    checkOutput("hazard res_hi", rd, 32'h0);
    readReg(1'b0, OFF_A, rd);
    checkOutput("A written mid-run", rd, 32'h0);

    // Accumulate three 2^32 products
    applyStimulus(1'b0, OFF_CTRL, 32'h8, 4'hF);
    applyStimulus(1'b0, OFF_A, 32'h0001_0000, 4'hF);
    applyStimulus(1'b0, OFF_B, 32'h0001_0000, 4'hF);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, OFF_CTRL, 32'h5, 4'hF);
      waitDone(1'b0, cycles, timedOut);
      checkOutput("acc timeout", 32'(timedOut), 32'h0);
    end
    readReg(1'b0, OFF_RES_HI, rd);
    checkOutput("acc res_hi", rd, 32'h3);
    readReg(1'b0, OFF_RES_LO, rd);
    checkOutput("acc res_lo", rd, 32'h0);
    readReg(1'b0, OFF_STATUS, rd);
    checkOutput("acc status", rd, 32'h2);

    // Unsigned accumulate overflow
    applyStimulus(1'b0, OFF_CTRL, 32'h8, 4'hF);
    applyStimulus(1'b0, OFF_A, 32'hFFFF_FFFF, 4'hF);
    applyStimulus(1'b0, OFF_B, 32'hFFFF_FFFF, 4'hF);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, OFF_CTRL, 32'h5, 4'hF);
      waitDone(1'b0, cycles, timedOut);
      checkOutput("ovf timeout", 32'(timedOut), 32'h0);
    end
    readReg(1'b0, OFF_RES_HI, rd);
    checkOutput("ovf res_hi", rd, 32'hFFFF_FFFC);
    readReg(1'b0, OFF_RES_LO, rd);
    checkOutput("ovf res_lo", rd, 32'h0000_0002);
    readReg(1'b0, OFF_STATUS, rd);
    checkOutput("ovf status", rd, 32'h6);
    applyStimulus(1'b0, OFF_CTRL, 32'h8, 4'hF);
    readReg(1'b0, OFF_STATUS, rd);
    checkOutput("clr status", rd, 32'h0);

    // Reset mid-operation aborts and clears everything
    applyStimulus(1'b0, OFF_A, 32'h0000_1234, 4'hF);
    applyStimulus(1'b0, OFF_B, 32'h0000_0010, 4'hF);
    applyStimulus(1'b0, OFF_CTRL, 32'h1, 4'hF);
    waitDone(1'b0, cycles, timedOut);
    readReg(1'b0, OFF_RES_LO, rd);
    checkOutput("pre-abort res_lo", rd, 32'h0001_2340);
    applyStimulus(1'b0, OFF_CTRL, 32'h1, 4'hF);
    repeat (10) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    checkOutput("abort busy", 32'(busyA), 32'h0);
    resetn = 1'b1;
    irqSeen = 0;
    repeat (40) begin
      @(negedge clk);
      if (irqA) irqSeen++;
    end
    checkOutput("abort irq count", 32'(irqSeen), 32'h0);
    readReg(1'b0, OFF_A, rd);
    checkOutput("abort A", rd, 32'h0);
    readReg(1'b0, OFF_B, rd);
    checkOutput("abort B", rd, 32'h0);
    readReg(1'b0, OFF_RES_LO, rd);
    checkOutput("abort res_lo", rd, 32'h0);
    readReg(1'b0, OFF_STATUS, rd);
    checkOutput("abort status", rd, 32'h0);

    // N=16, BPC=4 instance: signed 0x8000 squared
    applyStimulus(1'b1, OFF_A, 32'hFFFF_8000, 4'hF);
    readReg(1'b1, OFF_A, rd);
    checkOutput("n16 A zero-extend", rd, 32'h0000_8000);
    applyStimulus(1'b1, OFF_B, 32'h0000_8000, 4'hF);
    applyStimulus(1'b1, OFF_CTRL, 32'h3, 4'hF);
    waitDone(1'b1, cycles, timedOut);
    checkOutput("n16 latency", 32'(cycles), 32'd5);
    readReg(1'b1, OFF_RES_LO, rd);
    checkOutput("n16 res_lo", rd, 32'h4000_0000);
    readReg(1'b1, OFF_RES_HI, rd);
    checkOutput("n16 res_hi", rd, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/mmio_seq_multiplier.md
# mmio_seq_multiplier

Memory-mapped, parametrised sequential multiply/multiply-accumulate peripheral on the picorv32 look-ahead memory bus. Replaces the combinational array multiplier and its fixed A/B/result addresses. Adds start/busy/done handshaking, signed mode, accumulation with sticky overflow, and a configurable radix that trades latency for area. The system top decodes its reads through `hit`, alongside RAM and the `out_byte` port.

## Interface
- `N`, 32: operand width; legal 8..32.
- `BPC`, 1: multiplier bits retired per cycle; one of 1, 2, 4; `N % BPC == 0`.
- `BASE_ADDR`, 32'h0FFF_FFE0: register window base; 32-byte aligned.
- `clk`  in  1  system clock
- `resetn`  in  1  reset; one clock; reset is asynchronous and active-low
- `mem_la_read`  in  1  look-ahead read strobe
- `mem_la_write`  in  1  look-ahead write strobe
- `mem_la_addr`  in  32  byte address
- `mem_la_wdata`  in  32  write data
- `mem_la_wstrb`  in  4  byte enables
- `rdata`  out  32  registered read data
- `hit`  out  1  registered: previous-cycle read targeted this window
- `busy`  out  1  mirror of STATUS.BUSY
- `irq`  out  1  single-cycle pulse when DONE sets

## Operation
- Register map (offset from `BASE_ADDR`):
  - 0x00 A, RW, low N bits.
  - 0x04 B, RW, low N bits.
  - 0x08 CTRL, RW:
    - [0] START, write-1, self-clearing, reads 0.
    - [1] SIGNED.
    - [2] ACC.
    - [3] CLR, write-1, clears the result/accumulator and OVF; no effect while BUSY.
  - 0x0C STATUS, RO: [0] BUSY, [1] DONE (sticky), [2] OVF (sticky).
  - 0x10 RES_LO, RO.
  - 0x14 RES_HI, RO.
  - Other offsets read 0; writes to them are ignored.
- Writes to A and B honour `mem_la_wstrb` per byte. CTRL acts only when `wstrb[0]` is set. Widths below 32 bits are zero-extended on read.
- FSM states IDLE, RUN, FIN:
  - IDLE → RUN on a START write. Latch A, B, SIGNED and ACC into working copies. SIGNED=1 takes magnitudes and records the sign XOR. Clear DONE, set BUSY, load counter = N/BPC.
  - RUN: each cycle add (multiplicand × low BPC multiplier bits) shifted into the 2N-bit partial sum, shift the multiplier right by BPC, decrement the counter. At counter == 1, go to FIN.
  - FIN, one cycle:
    - Negate the product if the sign XOR is 1.
    - ACC=1: result = result + product mod 2^(2N). Set OVF on unsigned carry-out, or on signed overflow when SIGNED=1.
    - ACC=0: result = product.
    - Clear BUSY, set DONE, pulse `irq`, go to IDLE.
- The result is 2N bits, extended to 64 (sign-extended when SIGNED=1, else zero-extended) and split into RES_LO/RES_HI.
- Boundary rules:
  - START while BUSY: ignored.
  - A/B writes while BUSY update the registers but not the running op.
  - RES reads while BUSY return the previous result.
  - Reading STATUS clears DONE. If FIN sets DONE in the same cycle, the set wins.
  - Asserting `resetn` mid-op aborts it; all registers and outputs return to 0.

## Timing
- Reset values: `rdata`, `hit`, `busy`, `irq` = 0. All registers 0. FSM in IDLE.
- Read: `rdata`/`hit` are valid on the edge after the cycle `mem_la_read` is asserted with an in-window address. This matches the RAM's one-cycle registered read.
- Write: takes effect on the edge where `mem_la_write` is sampled.
- Latency: the START write edge is cycle 0. BUSY reads 1 from cycle 1. DONE=1, BUSY=0 and `irq` are high in cycle N/BPC + 1. Defaults give 33 cycles.
- Back-to-back: a START written in the cycle DONE sets is accepted.

## Structure
- Shared package/include `mmio_mul_defs.vh`: register offsets, CTRL/STATUS bit indices, FSM state encodings.
- One sub-module, `mul_radix_step`: combinational BPC-bit partial-product add (multiplicand, multiplier slice, partial sum → next partial sum).
- Bus decode, register file, FSM and accumulator stay in the top module.

## Test plan
- Unsigned, defaults: A=0xFFFF_FFFF, B=0xFFFF_FFFF, START → DONE at cycle 33, RES_LO=0x0000_0001, RES_HI=0xFFFF_FFFE. STATUS read then reads DONE=0.
- Signed: A=0xFFFF_FFFD (−3), B=7, SIGNED|START → RES_LO=0xFFFF_FFEB, RES_HI=0xFFFF_FFFF.
- Accumulate: CLR, then three runs of A=B=0x0001_0000 with ACC|START → RES_HI=3, RES_LO=0, OVF=0.
- Overflow: CLR, then two ACC runs of 0xFFFF_FFFF² → RES_HI=0xFFFF_FFFC, RES_LO=0x0000_0002, OVF=1.
- Hazards:
  - Second START at cycle 5 of a run → ignored; result matches the first operands.
  - Write A=0 mid-run → result unaffected.
  - `resetn` low at cycle 10 → all registers 0, BUSY=0, no `irq`.
- Build N=16, BPC=4: A=B=0x8000, SIGNED|START → DONE at cycle 5, RES_LO=0x4000_0000, RES_HI=0.
